// File: rtl/xbox_apb_host_regs.sv
// APB3 slave register file for the XBOX accelerator command/status port.
// SW writes drive host_regs plus one-cycle start strobes; accelerator status is held in shadow registers for SW reads.
module xbox_apb_host_regs #(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 12
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     psel,
  input  logic                     penable,
  input  logic                     pwrite,
  input  logic [ADDR_W-1:0]        paddr,
  input  logic [31:0]              pwdata,
  output logic [31:0]              prdata,
  output logic                     pready,
  output logic                     pslverr,
  output logic [NUM_REGS-1:0][31:0] host_regs,
  output logic [NUM_REGS-1:0]      host_regs_valid_pulse,
  input  logic [NUM_REGS-1:0][31:0] host_regs_data_out,
  input  logic [NUM_REGS-1:0]      host_regs_valid_out
);

  typedef enum logic [0:0] {IDLE, RD_WAIT} state_t;

  state_t                      state_reg, state_next;
  logic [NUM_REGS-1:0][31:0]   regs_reg, shadow_reg;
  logic [NUM_REGS-1:0]         shadow_valid_reg, pulse_reg, wr_hit;
  logic [31:0]                 prdata_reg, rd_value;
  logic                        rd_err_reg;
  logic [4:0]                  idx;
  logic                        legal, wr_fire, rd_fire;

  assign idx   = paddr[6:2];
  assign legal = (paddr < ADDR_W'(128));

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_hit
      assign wr_hit[gi] = wr_fire && legal && (idx == 5'(gi));
    end
  endgenerate

  // Read value uses pre-edge shadow state, so a same-cycle capture is not visible.
  assign rd_value = !legal ? 32'h0 :
                    (shadow_valid_reg[idx] ? shadow_reg[idx] : regs_reg[idx]);

  always_comb begin
    state_next = state_reg;
    wr_fire    = 1'b0;
    rd_fire    = 1'b0;
    pready     = 1'b0;
    pslverr    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (psel && penable) begin
          if (pwrite) begin
            wr_fire = 1'b1;
            pready  = 1'b1;
            pslverr = ~legal;
          end else begin
            rd_fire    = 1'b1;
            state_next = RD_WAIT;
          end
        end
      end
      RD_WAIT: begin
        pready     = 1'b1;
        pslverr    = rd_err_reg;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      prdata_reg <= 32'h0;
      rd_err_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (rd_fire) begin
        prdata_reg <= rd_value;
        rd_err_reg <= ~legal;
      end
    end
  end

  // Capture has priority over a write-driven clear of shadow_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs_reg         <= '0;
      shadow_reg       <= '0;
      shadow_valid_reg <= '0;
      pulse_reg        <= '0;
    end else begin
      pulse_reg <= wr_hit;
      for (int i = 0; i < NUM_REGS; i++) begin
        if (wr_hit[i]) regs_reg[i] <= pwdata;
        if (host_regs_valid_out[i]) begin
          shadow_reg[i]       <= host_regs_data_out[i];
          shadow_valid_reg[i] <= 1'b1;
        end else if (wr_hit[i]) begin
          shadow_valid_reg[i] <= 1'b0;
        end
      end
    end
  end

  assign prdata                = prdata_reg;
  assign host_regs             = regs_reg;
  assign host_regs_valid_pulse = pulse_reg;

endmodule

// File: tb/tb_xbox_apb_host_regs.sv
// Self-checking bench for xbox_apb_host_regs: APB writes/reads, status capture, error decode and reset.
module tb_xbox_apb_host_regs;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              psel, penable, pwrite;
  logic [11:0]       paddr;
  logic [31:0]       pwdata, prdata;
  logic              pready, pslverr;
  logic [31:0][31:0] host_regs, host_regs_data_out;
  logic [31:0]       host_regs_valid_pulse, host_regs_valid_out;

  typedef struct {
    logic [31:0] data;
    logic        err;
  } exp_t;
  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;
  int pulse3_count = 0;

  always #5 clk = ~clk;

  xbox_apb_host_regs #(.NUM_REGS(32), .ADDR_W(12)) dut (
    .clk(clk), .rst_n(rst_n), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr),
    .host_regs(host_regs), .host_regs_valid_pulse(host_regs_valid_pulse),
    .host_regs_data_out(host_regs_data_out), .host_regs_valid_out(host_regs_valid_out)
  );

  always @(negedge clk) if (host_regs_valid_pulse[3]) pulse3_count++;

  task automatic apb_write(input logic [11:0] a, input logic [31:0] d,
                           input logic cap_en, input int cap_idx, input logic [31:0] cap_data,
                           output logic rdy, output logic err);
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
    @(posedge clk); #1;
    penable = 1'b1;
    if (cap_en) begin
      host_regs_valid_out[cap_idx] = 1'b1;
      host_regs_data_out[cap_idx]  = cap_data;
    end
    @(negedge clk);
    rdy = pready; err = pslverr;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    host_regs_valid_out = '0;
  endtask

  task automatic apb_read(input logic [11:0] a, output logic [31:0] d,
                          output logic err, output int cyc);
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
    @(posedge clk); #1;
    penable = 1'b1;
    cyc = 1;
    @(negedge clk);
    while (!pready && cyc < 8) begin
      @(negedge clk);
      cyc++;
    end
    if (!pready) cyc = 99;
    d = prdata; err = pslverr;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic read_and_score(input string name, input logic [11:0] a, input int exp_cyc);
    logic [31:0] d; logic e; int cyc; exp_t x;
    apb_read(a, d, e, cyc);
    x = exp_q.pop_front();
    checks++;
    if (d !== x.data || e !== x.err || cyc != exp_cyc) begin
      errors++;
      $display("FAIL %s: got data=%h err=%b cycles=%0d, expected data=%h err=%b cycles=%0d",
               name, d, e, cyc, x.data, x.err, exp_cyc);
    end else
      $display("read %s addr=%h data=%h err=%b cycles=%0d", name, a, d, e, cyc);
  endtask

  task automatic test_reset;
    checks++;
    if (pready !== 1'b0 || pslverr !== 1'b0 || prdata !== 32'h0 ||
        host_regs !== '0 || host_regs_valid_pulse !== 32'h0) begin
      errors++;
      $display("FAIL reset_state: got pready=%b pslverr=%b prdata=%h pulse=%h, expected all 0",
               pready, pslverr, prdata, host_regs_valid_pulse);
    end
    exp_q.push_back('{32'h0, 1'b0});
    read_and_score("reset_read", 12'h000, 2);
  endtask

  task automatic test_write;
    logic rdy, err;
    apb_write(12'h000, 32'h1, 1'b0, 0, 32'h0, rdy, err);
    checks++;
    if (rdy !== 1'b1 || err !== 1'b0) begin
      errors++;
      $display("FAIL write_ready: got pready=%b pslverr=%b, expected 1 0", rdy, err);
    end
    checks++;
    if (host_regs_valid_pulse !== 32'h1 || host_regs[0] !== 32'h1) begin
      errors++;
      $display("FAIL write_pulse: got pulse=%h reg0=%h, expected 00000001 00000001",
               host_regs_valid_pulse, host_regs[0]);
    end
    @(posedge clk); #1;
    checks++;
    if (host_regs_valid_pulse !== 32'h0) begin
      errors++;
      $display("FAIL pulse_width: got pulse=%h, expected 0", host_regs_valid_pulse);
    end
    exp_q.push_back('{32'h1, 1'b0});
    read_and_score("write_readback", 12'h000, 2);
  endtask

  task automatic test_done_capture;
    logic rdy, err;
    @(posedge clk); #1;
    host_regs_valid_out[1] = 1'b1;
    host_regs_data_out[1]  = 32'h1;
    @(posedge clk); #1;
    host_regs_valid_out = '0;
    host_regs_data_out[1] = 32'hFFFF_FFFF;
    repeat (20) @(posedge clk);
    exp_q.push_back('{32'h1, 1'b0});
    read_and_score("done_capture", 12'h004, 2);
    apb_write(12'h004, 32'h5, 1'b0, 0, 32'h0, rdy, err);
    exp_q.push_back('{32'h5, 1'b0});
    read_and_score("shadow_cleared", 12'h004, 2);
  endtask

  task automatic test_illegal;
    logic rdy, err;
    logic [31:0][31:0] snap;
    snap = host_regs;
    apb_write(12'h080, 32'hDEAD, 1'b0, 0, 32'h0, rdy, err);
    checks++;
    if (rdy !== 1'b1 || err !== 1'b1) begin
      errors++;
      $display("FAIL illegal_write_err: got pready=%b pslverr=%b, expected 1 1", rdy, err);
    end
    checks++;
    if (host_regs_valid_pulse !== 32'h0 || host_regs !== snap) begin
      errors++;
      $display("FAIL illegal_write_effect: got pulse=%h or regs changed, expected no pulse and unchanged regs",
               host_regs_valid_pulse);
    end
    exp_q.push_back('{32'h0, 1'b1});
    read_and_score("illegal_read", 12'h0FC, 2);
  endtask

  task automatic test_collision;
    logic rdy, err;
    apb_write(12'h008, 32'h7, 1'b1, 2, 32'h9, rdy, err);
    checks++;
    if (host_regs[2] !== 32'h7 || host_regs_valid_pulse !== 32'h4) begin
      errors++;
      $display("FAIL collision_reg: got reg2=%h pulse=%h, expected 00000007 00000004",
               host_regs[2], host_regs_valid_pulse);
    end
    exp_q.push_back('{32'h9, 1'b0});
    read_and_score("collision_read", 12'h008, 2);
  endtask

  task automatic test_back_to_back;
    logic rdy, err;
    int start;
    start = pulse3_count;
    apb_write(12'h00C, 32'hA, 1'b0, 0, 32'h0, rdy, err);
    apb_write(12'h00C, 32'hB, 1'b0, 0, 32'h0, rdy, err);
    repeat (2) @(posedge clk);
    checks++;
    if (pulse3_count - start != 2 || host_regs[3] !== 32'hB) begin
      errors++;
      $display("FAIL back_to_back: got pulses=%0d reg3=%h, expected 2 0000000b",
               pulse3_count - start, host_regs[3]);
    end
  endtask

  task automatic test_reset_mid_read;
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 12'h000;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (pready !== 1'b0 || pslverr !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_read: got pready=%b pslverr=%b, expected 0 0", pready, pslverr);
    end
    psel = 1'b0; penable = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (pready !== 1'b0 || host_regs !== '0) begin
      errors++;
      $display("FAIL reset_mid_read_idle: got pready=%b, expected 0 with regs cleared", pready);
    end
    exp_q.push_back('{32'h0, 1'b0});
    read_and_score("read_after_reset", 12'h000, 2);
  endtask

  initial begin
    rst_n = 1'b0;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
    host_regs_data_out = '0; host_regs_valid_out = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_write();
    test_done_capture();
    test_illegal();
    test_collision();
    test_back_to_back();
    test_reset_mid_read();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
